// File: rtl/sevseg_scan_scheduler.sv
// sevseg_scan_scheduler: 8-digit seven-segment scan with per-frame arbitration, blanking gap and PWM.
// Define SEVSEG_LEADING_ZERO_BLANK_EN to darken digits above the most significant nonzero nibble.
module sevseg_scan_scheduler #(
  parameter int BRIGHT_W    = 3,
  parameter int BLANK_TICKS = 1
) (
  input  logic                clk_7seg,
  input  logic                Rst,
  input  logic                dbg_req,
  input  logic [31:0]         dbg_val,
  input  logic                mmio_req,
  input  logic [31:0]         mmio_val,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [7:0]          an,
  output logic [6:0]          sev_out,
  output logic                frame_start,
  output logic                src_sel
);
  localparam int ON_TICKS = 2 ** BRIGHT_W;
  localparam int MAX_T = ON_TICKS > BLANK_TICKS ? ON_TICKS : BLANK_TICKS;
  localparam int TW = MAX_T > 1 ? $clog2(MAX_T) : 1;
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic {BLANK, LIT} state_t;
  state_t              st_q, st_d;
  logic [2:0]          dig_q, dig_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic                prim_q;
  logic [31:0]         val_q, val_d;
  logic [BRIGHT_W-1:0] br_q, br_d;
  logic                src_d, wrap, fs_d, lit_on;
  logic [3:0]          nib;
  logic [7:0]          show_d, an_d;
  logic [6:0]          sev_d;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  logic [7:0]          show_q, lz;
`endif
  // prim_q holds the reset state one extra cycle so the first frame opens with a real snapshot
  always_comb begin
    wrap   = st_q == BLANK ? tick_q == TW'(BLANK_TICKS - 1) : tick_q == TW'(ON_TICKS - 1);
    tick_d = (prim_q || wrap) ? '0 : tick_q + 1'b1;
    st_d   = (!prim_q && wrap) ? (st_q == BLANK ? LIT : BLANK) : st_q;
    dig_d  = (!prim_q && wrap && st_q == LIT) ? dig_q + 3'd1 : dig_q;
    src_d  = frame_start ? (dbg_req || (!mmio_req && src_sel)) : src_sel;
    val_d  = frame_start ? (src_d ? dbg_val : mmio_val) : val_q;
    br_d   = frame_start ? brightness : br_q;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    lz = 8'h01;
    for (int i = 1; i < 8; i++) lz[i] = |(val_d >> (4 * i));
    show_d = frame_start ? lz : show_q;
`else
    show_d = 8'hFF;
`endif
    nib    = val_d[{dig_d, 2'b00} +: 4];
    fs_d   = st_d == BLANK && dig_d == 3'd0 && tick_d == '0;
    lit_on = st_d == LIT && tick_d <= TW'(br_d) && show_d[dig_d];
    an_d   = lit_on ? ~(8'b1 << dig_d) : 8'hFF;
    sev_d  = st_d == LIT ? SEG[nib] : 7'h7F;
  end
  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      st_q        <= BLANK;
      dig_q       <= '0;
      tick_q      <= '0;
      prim_q      <= 1'b1;
      val_q       <= '0;
      br_q        <= '0;
      an          <= 8'hFF;
      sev_out     <= 7'h7F;
      frame_start <= 1'b0;
      src_sel     <= 1'b0;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      show_q      <= 8'hFF;
`endif
    end else begin
      st_q        <= st_d;
      dig_q       <= dig_d;
      tick_q      <= tick_d;
      prim_q      <= 1'b0;
      val_q       <= val_d;
      br_q        <= br_d;
      an          <= an_d;
      sev_out     <= sev_d;
      frame_start <= fs_d;
      src_sel     <= src_d;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
      show_q      <= show_d;
`endif
    end
  end
endmodule

// File: tb/tb_sevseg_scan_scheduler.sv
// tb_sevseg_scan_scheduler: directed frame-by-frame check of scan, arbitration, PWM and reset.
module tb_sevseg_scan_scheduler;
  logic        clk_7seg = 1'b0, Rst = 1'b1, dbg_req = 1'b0, mmio_req = 1'b0;
  logic [31:0] dbg_val = '0, mmio_val = '0;
  logic [2:0]  brightness = '0;
  logic [7:0]  an;
  logic [6:0]  sev_out;
  logic        frame_start, src_sel;
  int          n_vec = 0, n_err = 0, lo_cnt = 0;
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  sevseg_scan_scheduler dut (
    .clk_7seg(clk_7seg), .Rst(Rst), .dbg_req(dbg_req), .dbg_val(dbg_val),
    .mmio_req(mmio_req), .mmio_val(mmio_val), .brightness(brightness),
    .an(an), .sev_out(sev_out), .frame_start(frame_start), .src_sel(src_sel)
  );
  always #5 clk_7seg = ~clk_7seg;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk_7seg);
    @(negedge clk_7seg);
  endtask
  function automatic logic [7:0] shown(input logic [31:0] v);
    logic [7:0] s;
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    s = 8'h01;
    for (int i = 1; i < 8; i++) s[i] = (v >> (4 * i)) != 0;
`else
    s = 8'hFF;
`endif
    return s;
  endfunction
  // frame position p: p%9==0 is the blanking cycle, otherwise LIT tick p%9-1 of digit p/9
  task automatic frame(input logic [31:0] v, input logic [2:0] br, input logic src,
                       input int p0, input int p1);
    logic [7:0] sh, ea;
    logic [6:0] es;
    int d, t;
    sh = shown(v);
    for (int p = p0; p <= p1; p++) begin
      d = p / 9;
      t = p % 9;
      ea = 8'hFF;
      es = 7'h7F;
      if (t != 0) begin
        es = SEG[v[4*d +: 4]];
        if (t - 1 <= int'(br) && sh[d]) ea = ~(8'b1 << d);
      end
      check($sformatf("an v%h p%0d", v, p), an, ea);
      check($sformatf("sev v%h p%0d", v, p), sev_out, es);
      check($sformatf("fs v%h p%0d", v, p), frame_start, p == 0);
      if (p > 0) check($sformatf("src v%h p%0d", v, p), src_sel, src);
      if (an != 8'hFF) lo_cnt++;
      step();
    end
  endtask
  initial begin
    mmio_req = 1'b1;
    mmio_val = 32'h1234_5678;
    brightness = 3'd7;
    repeat (3) step();
    check("rst an", an, 8'hFF);
    check("rst sev", sev_out, 7'h7F);
    check("rst fs", frame_start, 1'b0);
    check("rst src", src_sel, 1'b0);
    Rst = 1'b0;
    step();
    frame(32'h1234_5678, 3'd7, 1'b0, 0, 19);
    dbg_req = 1'b1;
    dbg_val = 32'hDEAD_BEEF;
    frame(32'h1234_5678, 3'd7, 1'b0, 20, 71);
    frame(32'hDEAD_BEEF, 3'd7, 1'b1, 0, 29);
    brightness = 3'd0;
    frame(32'hDEAD_BEEF, 3'd7, 1'b1, 30, 71);
    lo_cnt = 0;
    frame(32'hDEAD_BEEF, 3'd0, 1'b1, 0, 29);
    dbg_req = 1'b0;
    mmio_req = 1'b0;
    dbg_val = 32'h0000_00A5;
    mmio_val = 32'h5555_5555;
    frame(32'hDEAD_BEEF, 3'd0, 1'b1, 30, 71);
    check("dim lo count", lo_cnt, 8);
    lo_cnt = 0;
    frame(32'h0000_00A5, 3'd0, 1'b1, 0, 29);
    mmio_req = 1'b1;
    mmio_val = 32'h0000_0A05;
    brightness = 3'd5;
    frame(32'h0000_00A5, 3'd0, 1'b1, 30, 71);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    check("a5 lo count", lo_cnt, 2);
`else
    check("a5 lo count", lo_cnt, 8);
`endif
    frame(32'h0000_0A05, 3'd5, 1'b0, 0, 38);
    Rst = 1'b1;
    step();
    check("midrst an", an, 8'hFF);
    check("midrst sev", sev_out, 7'h7F);
    check("midrst fs", frame_start, 1'b0);
    check("midrst src", src_sel, 1'b0);
    Rst = 1'b0;
    mmio_val = 32'h0000_0000;
    step();
    frame(32'h0000_0000, 3'd5, 1'b0, 0, 71);
    frame(32'h0000_0000, 3'd5, 1'b0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
